// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: load extraction and registered register-file write
// Optional misaligned-load trap enabled by defining WB_MISALIGN_TRAP_EN.
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb_en,
  input  logic              ex_is_load,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              trap_valid,
  output logic [XLEN-1:0]   trap_addr
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            state;
  logic [REG_AW-1:0] ld_rd;
  logic              ld_wb_en;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr;
  logic              accept;
  logic              load_ok;
  logic              misaligned;

  assign ex_ready = rst_n && (state == IDLE);
  assign accept   = ex_valid && ex_ready;

  // Reserved encodings 011/110/111 are swallowed without touching memory.
  assign load_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                   (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);

`ifdef WB_MISALIGN_TRAP_EN
  assign misaligned = ((ex_funct3[1:0] == 2'b01) && ex_result[0]) ||
                      ((ex_funct3 == 3'b010) && (ex_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[16 +: 16] : word[0 +: 16];
    case (f3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = word;
    endcase
  endfunction

`ifdef WB_MISALIGN_TRAP_EN
  logic            trap_valid_q;
  logic [XLEN-1:0] trap_addr_q;
  assign trap_valid = trap_valid_q;
  assign trap_addr  = trap_addr_q;
`else
  assign trap_valid = 1'b0;
  assign trap_addr  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      ld_rd     <= '0;
      ld_wb_en  <= 1'b0;
      ld_funct3 <= 3'b000;
      ld_addr   <= 2'b00;
`ifdef WB_MISALIGN_TRAP_EN
      trap_valid_q <= 1'b0;
      trap_addr_q  <= '0;
`endif
    end else begin
      rf_we <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      trap_valid_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (!ex_is_load) begin
              if (ex_wb_en && (ex_rd != '0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= ex_rd;
                rf_wdata <= ex_result;
              end
            end else if (load_ok && !misaligned) begin
              ld_rd     <= ex_rd;
              ld_wb_en  <= ex_wb_en;
              ld_funct3 <= ex_funct3;
              ld_addr   <= ex_result[1:0];
              state     <= WAIT_MEM;
            end
`ifdef WB_MISALIGN_TRAP_EN
            else if (load_ok && misaligned) begin
              trap_valid_q <= 1'b1;
              trap_addr_q  <= ex_result;
            end
`endif
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            if (ld_wb_en && (ld_rd != '0)) begin
              rf_we    <= 1'b1;
              rf_waddr <= ld_rd;
              rf_wdata <= extract(ld_funct3, ld_addr, mem_rdata);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with directed and random transactions
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_wb_en;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        trap_valid;
  logic [31:0] trap_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
    .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_result(ex_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .trap_valid(trap_valid), .trap_addr(trap_addr)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input bit exp_we, input logic [4:0] rd,
                             input logic [31:0] d);
    if (exp_we) begin
      m_waddr = rd;
      m_wdata = d;
    end
    check({tag, "_we"}, {31'b0, rf_we}, {31'b0, exp_we});
    check({tag, "_waddr"}, {27'b0, rf_waddr}, {27'b0, m_waddr});
    check({tag, "_wdata"}, rf_wdata, m_wdata);
    check({tag, "_trap"}, {31'b0, trap_valid}, 32'd0);
  endtask

  // Reference: shift the addressed lane down, mask, and wrap negative values.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * a)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (a / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef WB_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (addr % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic do_alu(input logic [4:0] rd, input bit wb_en, input logic [31:0] res);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_wb_en = wb_en;
    ex_funct3 = 3'($urandom); ex_result = res;
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    step();
    ex_valid = 1'b0; mem_rvalid = 1'b0;
    check_write("alu", wb_en && (rd != 0), rd, res);
    check("alu_ready", {31'b0, ex_ready}, 32'd1);
  endtask

  task automatic do_load(input logic [4:0] rd, input bit wb_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] word,
                         input int delay, input bit early);
    bit reserved;
    reserved = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_wb_en = wb_en;
    ex_funct3 = f3; ex_result = addr;
    mem_rvalid = early; mem_rdata = ~word;
    step();
    ex_valid = 1'b0; mem_rvalid = 1'b0;
    if (reserved) begin
      check_write("ld_rsv", 1'b0, rd, 32'd0);
      check("ld_rsv_ready", {31'b0, ex_ready}, 32'd1);
      return;
    end
    if (model_misaligned(f3, addr)) begin
      check("trap_valid", {31'b0, trap_valid}, 32'd1);
      check("trap_addr", trap_addr, addr);
      check("trap_we", {31'b0, rf_we}, 32'd0);
      check("trap_ready", {31'b0, ex_ready}, 32'd1);
      step();
      check("trap_pulse", {31'b0, trap_valid}, 32'd0);
      return;
    end
    check("ld_wait_ready", {31'b0, ex_ready}, 32'd0);
    check("ld_wait_we", {31'b0, rf_we}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd1; ex_wb_en = 1'b1;
      step();
      check("ld_stall_ready", {31'b0, ex_ready}, 32'd0);
      check("ld_stall_we", {31'b0, rf_we}, 32'd0);
    end
    ex_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = word;
    step();
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    check_write("ld", wb_en && (rd != 0), rd, model_load(f3, addr[1:0], word));
    check("ld_done_ready", {31'b0, ex_ready}, 32'd1);
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    m_waddr = 5'd0; m_wdata = 32'd0;
    rst_n = 1'b0; ex_valid = 1'b0; ex_rd = 5'd0; ex_wb_en = 1'b0; ex_is_load = 1'b0;
    ex_funct3 = 3'd0; ex_result = 32'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    step(); step();
    check("rst_ready", {31'b0, ex_ready}, 32'd0);
    check_write("rst", 1'b0, 5'd0, 32'd0);
    check("rst_trap_addr", trap_addr, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'b0, ex_ready}, 32'd1);

    do_alu(5'd5, 1'b1, 32'h1234_5678);
    do_alu(5'd0, 1'b1, 32'hDEAD_BEEF);
    do_alu(5'd7, 1'b0, 32'hCAFE_0001);

    do_load(5'd9, 1'b1, 3'd0, 32'h0000_0103, 32'h80FF_0000, 1, 1'b1);
    do_load(5'd9, 1'b1, 3'd4, 32'h0000_0103, 32'h80FF_0000, 1, 1'b0);
    do_load(5'd10, 1'b1, 3'd1, 32'h0000_0202, 32'h8001_7FFF, 0, 1'b0);
    do_load(5'd11, 1'b1, 3'd5, 32'h0000_0202, 32'h8001_7FFF, 2, 1'b0);
    do_load(5'd12, 1'b1, 3'd2, 32'h0000_0200, 32'h8001_7FFF, 0, 1'b0);
    do_load(5'd0, 1'b1, 3'd2, 32'h0000_0200, 32'h1111_2222, 0, 1'b0);
    do_load(5'd13, 1'b1, 3'd2, 32'h0000_1002, 32'hA5A5_5A5A, 0, 1'b0);
    do_load(5'd14, 1'b1, 3'd3, 32'h0000_0000, 32'h1, 0, 1'b0);

    // Three consecutive accepts give three consecutive writes.
    for (int i = 1; i <= 3; i++) begin
      ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'(i); ex_wb_en = 1'b1;
      ex_result = 32'h100 * i;
      step();
      check_write("b2b", 1'b1, 5'(i), 32'h100 * i);
    end
    ex_valid = 1'b0;
    step();
    check("b2b_end_we", {31'b0, rf_we}, 32'd0);

    // ALU accepted in the load's write cycle writes one cycle later.
    do_load(5'd20, 1'b1, 3'd2, 32'h0000_0040, 32'h0BAD_F00D, 1, 1'b0);
    do_alu(5'd21, 1'b1, 32'h7777_0000);

    // Reset while waiting drops the load.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd22; ex_wb_en = 1'b1;
    ex_funct3 = 3'd2; ex_result = 32'h0;
    step();
    ex_valid = 1'b0;
    rst_n = 1'b0;
    step();
    m_waddr = 5'd0; m_wdata = 32'd0;
    check("rstw_ready", {31'b0, ex_ready}, 32'd0);
    check_write("rstw", 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    check("rstw_ready_after", {31'b0, ex_ready}, 32'd1);
    check_write("rstw_rvalid", 1'b0, 5'd0, 32'd0);
    step();
    check_write("rstw_later", 1'b0, 5'd0, 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [4:0]  rd;
      bit          en;
      rd = 5'($urandom);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 0)
        do_alu(rd, en, $urandom);
      else
        do_load(rd, en, f3_tab[$urandom_range(0, 7)], $urandom, $urandom,
                $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
